// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PDM constants, default widths and rate type
package pdm_pkg;

  localparam int PDM_DW_DEFAULT = 16;
  localparam int PDM_AW_DEFAULT = PDM_DW_DEFAULT + 4;

  // Interpolation/decimation rate, shared with the receive-side decimator.
  typedef logic [15:0] rate_t;

  function automatic int pdm_fs(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/sd_mod_core.sv
// rtl/sd_mod_core.sv - sigma-delta loop; PDM_MOD_ORDER2_EN selects the second-order loop
module sd_mod_core
  import pdm_pkg::*;
#(
  parameter int DW = PDM_DW_DEFAULT,
  parameter int AW = PDM_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_cur,
  output logic          o_pdm
);

  localparam logic [AW-1:0] FS_A = AW'(pdm_fs(DW));

  logic [AW-1:0] w_cur_x;
  logic [AW-1:0] w_fb;
  logic          w_y;
  logic          r_pdm;

  assign w_cur_x = {{(AW-DW){i_cur[DW-1]}}, i_cur};

`ifdef PDM_MOD_ORDER2_EN
  logic [AW-1:0] r_i1;
  logic [AW-1:0] r_i2;
  logic [AW:0]   w_s1;
  logic [AW:0]   w_s2;

  // Sums carry one guard bit; a guard/sign disagreement means overflow.
  function automatic logic [AW-1:0] sat(input logic [AW:0] v);
    if (v[AW] == v[AW-1]) return v[AW-1:0];
    return v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  endfunction

  assign w_y  = !r_i2[AW-1];
  assign w_s1 = {r_i1[AW-1], r_i1} + {w_cur_x[AW-1], w_cur_x} - {w_fb[AW-1], w_fb};
  assign w_s2 = {r_i2[AW-1], r_i2} + {r_i1[AW-1], r_i1} - {w_fb[AW-1], w_fb};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_pdm <= 1'b0;
    end else if (i_en) begin
      r_i1  <= sat(w_s1);
      r_i2  <= sat(w_s2);
      r_pdm <= w_y;
    end
  end
`else
  logic [AW-1:0] r_i1;

  assign w_y = !r_i1[AW-1];

  // i1 stays within [-2FS, 2FS), so AW >= DW+2 needs no clamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1  <= '0;
      r_pdm <= 1'b0;
    end else if (i_en) begin
      r_i1  <= r_i1 + w_cur_x - w_fb;
      r_pdm <= w_y;
    end
  end
`endif

  assign w_fb  = w_y ? FS_A : -FS_A;
  assign o_pdm = r_pdm;

endmodule

// File: rtl/pdm_modulator.sv
// rtl/pdm_modulator.sv - PCM to PDM modulator with zero-order hold; loop order via PDM_MOD_ORDER2_EN
module pdm_modulator
  import pdm_pkg::*;
#(
  parameter int DW = PDM_DW_DEFAULT,
  parameter int AW = DW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  rate_t         interp_num,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          pdm_out,
  output logic          sample_tick,
  output logic          underrun
);

  logic [DW-1:0] r_cur;
  logic [DW-1:0] r_buf;
  logic          r_buf_v;
  rate_t         r_cnt;
  logic          r_tick;
  logic          r_under;
  logic          w_load;
  logic          w_accept;

  // >= lets a lowered interp_num reload immediately instead of wrapping cnt.
  assign w_load    = en && (r_cnt >= interp_num);
  assign din_ready = !r_buf_v || w_load;
  assign w_accept  = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur   <= '0;
      r_buf   <= '0;
      r_buf_v <= 1'b0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_tick  <= 1'b0;
      r_under <= 1'b0;
      if (en) r_cnt <= w_load ? '0 : r_cnt + 16'd1;
      if (w_load) begin
        if (r_buf_v) begin
          r_cur  <= r_buf;
          r_tick <= 1'b1;
        end else begin
          r_under <= 1'b1;
        end
      end
      if (w_accept) begin
        r_buf   <= din;
        r_buf_v <= 1'b1;
      end else if (w_load) begin
        r_buf_v <= 1'b0;
      end
    end
  end

  sd_mod_core #(
    .DW(DW),
    .AW(AW)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .i_en (en),
    .i_cur(r_cur),
    .o_pdm(pdm_out)
  );

  assign sample_tick = r_tick;
  assign underrun    = r_under;

endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- Transmit-side counterpart of the PDM-to-PCM CIC decimator.
- Accepts signed PCM samples over a valid/ready handshake and holds each sample for a programmable number of bit periods (zero-order-hold interpolation).
- Converts the held samples to a 1-bit pulse-density stream, one bit per enabled clk, using a sigma-delta modulator.
- Drives a DAC/speaker PDM pin or a loopback into the receive chain.

Parameters:
- DW, 16: PCM sample width (signed two's complement); full scale FS = 2^(DW-1).
- AW, DW+4: modulator accumulator width (signed).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; modulator and bit counter advance only when high
- interp_num  in  16  bit periods per sample minus 1 (hold length = interp_num+1)
- din  in  DW  signed PCM sample
- din_valid  in  1  sample offered
- din_ready  out  1  sample accepted when din_valid && din_ready
- pdm_out  out  1  PDM bit stream
- sample_tick  out  1  1-cycle pulse: new sample loaded into modulator
- underrun  out  1  1-cycle pulse: load point reached with no buffered sample

Behaviour:
- State:
  - cur (DW): sample being modulated.
  - buf (DW) + buf_v: one-entry input buffer.
  - cnt (16): bit counter.
  - i1, i2 (AW): integrators.
- Reset values:
  - cur=0, buf=0, buf_v=0, cnt=0, i1=0, i2=0.
  - pdm_out=0, sample_tick=0, underrun=0.
- din_ready is combinational: !buf_v || load. Accept and load in the same cycle leaves buf_v=1 with the new data.
- load = en && (cnt >= interp_num). Use >=, not ==, so that lowering interp_num mid-hold reloads at once with no 16-bit wrap.
- Each en cycle:
  - If load: cnt<=0; otherwise cnt<=cnt+1.
- On load:
  - If buf_v: cur<=buf, buf_v cleared (unless refilled the same cycle), sample_tick<=1.
  - Otherwise: cur is kept (last sample repeats), underrun<=1.
- sample_tick and underrun are 0 in every other cycle, including all en=0 cycles.
- en=0:
  - cnt, cur, i1, i2 and pdm_out are held.
  - The handshake still fills buf.
- First-order modulator (default), each en cycle:
  - y = (i1 >= 0); fb = y ? +FS : -FS.
  - i1 <= i1 + sext(cur) - fb; pdm_out <= y.
  - Latency: pdm_out reflects the accumulator state of the previous cycle (1 clk).
- Width: input range [-FS, FS-1] bounds i1 to [-2FS, 2FS). AW ≥ DW+2 never overflows.
- Ones density ≈ (cur+FS)/(2FS).
- Reset mid-stream: all state returns to reset values in the same edge. Any buffered sample is discarded.

Optional Feature:
- Macro PDM_MOD_ORDER2_EN.
- Defined: second-order modulator. Each en cycle:
  - y = (i2 >= 0); fb = y ? +FS : -FS.
  - i1 <= sat(i1 + cur - fb); i2 <= sat(i2 + i1_old - fb).
  - sat clamps to the AW signed range.
  - Stable for |cur| ≤ FS/2. Larger inputs rely on saturation.
- Undefined:
  - First-order loop only; i2 is absent.
  - No saturation logic is generated.

Decomposition:
- Shared package pdm_pkg:
  - FS constant function of DW.
  - Default DW/AW.
  - Shared interp/dec rate typedef (16-bit), common with the decimator.
- One sub-module, sd_mod_core: integrators, feedback and the order-select macro.
- Top level owns the handshake, buffer and cnt.

Test Plan:
- Zero input, order 1: reset, din=0 accepted, en=1, interp_num=3 -> after load, pdm_out is 1,0,1,0,... Exactly 50% ones over 1024 bits.
- Positive constant: din=16384 (FS/2), interp_num=15 -> exactly 3 ones per 4 bits in steady state (768 of 1024). No underrun while a sample is re-offered each hold period.
- Negative full scale: din=-32768 from reset state -> a single 1, then all 0. din=32767 -> density ≥ 0.9999 over 65536 bits.
- Handshake/underrun:
  - Stop din_valid after 2 samples, interp_num=7 -> sample_tick at cnt wrap for each sample.
  - Then an underrun pulse every 8 en cycles; cur repeats.
  - din_ready=0 while buf full with no load.
- Enable/reset edge cases:
  - Drop en for 5 cycles mid-hold -> pdm_out, cnt and i1 frozen; handshake still accepts into buf.
  - Lower interp_num from 100 to 2 at cnt=50 -> load next cycle.
  - Assert rst mid-stream -> all outputs 0 next cycle.
- PDM_MOD_ORDER2_EN, din=0 -> pdm_out period-4 pattern 1,0,0,1 repeating.
  - Sweep din=±16000 -> decimated ones count within ±1% of (din+FS)/(2FS).
